otter_mmio_hub: RTL

Parametrised memory-mapped I/O hub between the OTTER MCU IOBUS and board peripherals. It replaces hand-coded per-port address decode with:
- N synchronised input words and N registered output words.
- An edge-triggered interrupt controller with pending and mask registers, driving the MCU INTR line.
- A receive FIFO that buffers keyboard scancodes so bursts are not lost between interrupt services.

---
 rtl/otter_mmio_pkg.sv | 35 +++
 rtl/mmio_sync_fifo.sv | 58 +++++
 rtl/otter_mmio_hub.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/otter_mmio_pkg.sv
// Shared constants for the OTTER MMIO hub: register offsets from BASE_AD
// and the FIFO_STAT bit layout, plus a helper that packs the status word.
package otter_mmio_pkg;

    // Register offsets relative to the hub base address
    localparam logic [31:0] OFS_IN        = 32'h000;
    localparam logic [31:0] OFS_OUT       = 32'h020;
    localparam logic [31:0] OUT_STRIDE    = 32'h020;
    localparam logic [31:0] OFS_FIFO_DATA = 32'h100;
    localparam logic [31:0] OFS_FIFO_STAT = 32'h104;
    localparam logic [31:0] OFS_IRQ_PEND  = 32'h108;
    localparam logic [31:0] OFS_IRQ_MASK  = 32'h10C;

    // FIFO_STAT field positions
    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_COUNT_LSB = 16;
    localparam int unsigned STAT_COUNT_W   = 7;

    // Assemble the FIFO_STAT read value
    function automatic logic [31:0] fifo_stat(input logic [STAT_COUNT_W-1:0] count,
                                              input logic ovf,
                                              input logic full,
                                              input logic empty);
        logic [31:0] s;
        s = '0;
        s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_FULL_BIT]  = full;
        s[STAT_EMPTY_BIT] = empty;
        return s;
    endfunction

endpackage

// File: rtl/mmio_sync_fifo.sv
// Synchronous FIFO for the hub receive path.
// Ports: CLK, RST (sync, active-high); push/din write, pop advances head;
// dout is the head entry, empty/full/count describe occupancy.
// A pop while empty is ignored; a push while full only succeeds when a pop
// in the same cycle frees a slot.
module mmio_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage and pointers; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/otter_mmio_hub.sv
// Memory-mapped I/O hub for the OTTER IOBUS: synchronised input words,
// registered output words, edge-triggered interrupt controller and a
// receive FIFO for keyboard scancodes.
// Ports: CLK, RST (sync, active-high); IOBUS_ADDR/IOBUS_OUT/IOBUS_WR from
// the CPU, IOBUS_IN combinational read data; IN_DATA and IRQ_SRC async board
// inputs; OUT_DATA registered outputs; RX_DATA/RX_VALID FIFO push;
// INTR registered interrupt request.
module otter_mmio_hub
    import otter_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_AD    = 32'h11000000,
    parameter int unsigned NUM_IN     = 2,
    parameter int unsigned NUM_OUT    = 2,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_W     = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [31:0]              IOBUS_ADDR,
    input  logic [31:0]              IOBUS_OUT,
    input  logic                     IOBUS_WR,
    output logic [31:0]              IOBUS_IN,
    input  logic [NUM_IN*32-1:0]     IN_DATA,
    output logic [NUM_OUT*OUT_W-1:0] OUT_DATA,
    input  logic [NUM_IRQ-1:0]       IRQ_SRC,
    input  logic [FIFO_W-1:0]        RX_DATA,
    input  logic                     RX_VALID,
    output logic                     INTR
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]              off;
    logic [NUM_IN*32-1:0]     in_s1, in_s2;
    logic [NUM_IRQ-1:0]       irq_s1, irq_s2, irq_prev;
    logic [NUM_IRQ-1:0]       pending, mask;
    logic                     intr_q;
    logic [NUM_OUT*OUT_W-1:0] out_q;
    logic [NUM_OUT-1:0]       out_we;
    logic                     ovf;
    logic                     wr_pop, wr_stat, wr_pend, wr_mask;
    logic [FIFO_W-1:0]        fifo_dout;
    logic                     fifo_empty, fifo_full;
    logic [CW-1:0]            fifo_count;
    logic                     wr_data_unused;

    assign off      = IOBUS_ADDR - BASE_AD;
    assign wr_pop   = IOBUS_WR && (off == OFS_FIFO_DATA);
    assign wr_stat  = IOBUS_WR && (off == OFS_FIFO_STAT);
    assign wr_pend  = IOBUS_WR && (off == OFS_IRQ_PEND);
    assign wr_mask  = IOBUS_WR && (off == OFS_IRQ_MASK);
    assign OUT_DATA = out_q;
    assign INTR     = intr_q;
    assign wr_data_unused = ^IOBUS_OUT;

    // Output register write enables; with NUM_OUT=8 the last slot aliases
    // FIFO_DATA and the FIFO register takes the access.
    always_comb begin
        out_we = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            if (IOBUS_WR && (off == OFS_OUT + OUT_STRIDE * 32'(j)) && (off < OFS_FIFO_DATA)) begin
                out_we[j] = 1'b1;
            end
        end
    end

    mmio_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FIFO_W)
    ) u_rx_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (RX_VALID),
        .pop   (wr_pop),
        .din   (RX_DATA),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Synchronisers, interrupt controller, output registers and overflow flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            in_s1    <= '0;
            in_s2    <= '0;
            irq_s1   <= '0;
            irq_s2   <= '0;
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
            intr_q   <= 1'b0;
            out_q    <= '0;
            ovf      <= 1'b0;
        end else begin
            in_s1    <= IN_DATA;
            in_s2    <= in_s1;
            irq_s1   <= IRQ_SRC;
            irq_s2   <= irq_s1;
            irq_prev <= irq_s2;
            // A new edge wins over a simultaneous write-1-to-clear
            pending  <= (pending & ~(wr_pend ? IOBUS_OUT[NUM_IRQ-1:0] : '0))
                        | (irq_s2 & ~irq_prev);
            if (wr_mask) begin
                mask <= IOBUS_OUT[NUM_IRQ-1:0];
            end
            intr_q <= |(pending & mask);
            for (int unsigned j = 0; j < NUM_OUT; j++) begin
                if (out_we[j]) begin
                    out_q[j*OUT_W +: OUT_W] <= IOBUS_OUT[OUT_W-1:0];
                end
            end
            // A push into a full FIFO is lost unless a pop frees a slot this cycle
            ovf <= (ovf && !wr_stat) || (RX_VALID && fifo_full && !wr_pop);
        end
    end

    // Combinational read mux; unmapped offsets return zero
    always_comb begin
        IOBUS_IN = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (off == OFS_IN + 32'(4 * i)) begin
                IOBUS_IN = in_s2[i*32 +: 32];
            end
        end
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            if ((off == OFS_OUT + OUT_STRIDE * 32'(j)) && (off < OFS_FIFO_DATA)) begin
                IOBUS_IN = 32'(out_q[j*OUT_W +: OUT_W]);
            end
        end
        case (off)
            OFS_FIFO_DATA: IOBUS_IN = fifo_empty ? '0 : 32'(fifo_dout);
            OFS_FIFO_STAT: IOBUS_IN = fifo_stat(STAT_COUNT_W'(fifo_count), ovf, fifo_full, fifo_empty);
            OFS_IRQ_PEND:  IOBUS_IN = 32'(pending);
            OFS_IRQ_MASK:  IOBUS_IN = 32'(mask);
            default:       ;
        endcase
    end

endmodule
